sn_stream_decoder: RTL and testbench

- Downstream stage of the stochastic datapath: consumes a serial stochastic bitstream (adder/multiplier output) and converts it back to binary.
- Counts ones over a programmable window of 2^L bits and emits unipolar count plus bipolar signed value through a valid/ready output register.
- Window width sized so a full window of ones never overflows; no sample is ever skipped between windows.
- Supports continuous and one-shot conversion.

---
 rtl/sn_pkg.sv | 35 +++
 rtl/sn_window_counter.sv | 71 +++++++
 rtl/sn_stream_decoder.sv | 117 +++++++++++
 tb/tb_sn_stream_decoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sn_pkg.sv
// Shared definitions for the stochastic-number stream decoder: FSM state
// encoding, default window size and the unipolar-to-bipolar conversion.
package sn_pkg;

  localparam int SN_MAX_LOG2_LEN = 8;

  // Wide enough for any window exponent a 4-bit win_log2 can express.
  localparam int SN_WIDE_CNT_W = 17;
  localparam int SN_WIDE_BIP_W = 18;

  typedef enum logic [1:0] {
    SN_IDLE = 2'd0,
    SN_RUN  = 2'd1,
    SN_DONE = 2'd2
  } sn_state_e;

  // Plain constants so the FSM register stays a simple logic vector.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bipolar value of a window: 2*count - 2^L, computed exactly in a wide
  // signed result; callers size-cast down to their own output width.
  function automatic logic signed [SN_WIDE_BIP_W-1:0] sn_bipolar(
    input logic [SN_WIDE_CNT_W-1:0] count,
    input logic [3:0]               log2
  );
    logic [SN_WIDE_BIP_W-1:0] w_twice;
    logic [SN_WIDE_BIP_W-1:0] w_len;
    w_twice = {count, 1'b0};
    w_len   = {{(SN_WIDE_BIP_W-1){1'b0}}, 1'b1} << log2;
    return $signed(w_twice - w_len);
  endfunction

endpackage

// File: rtl/sn_window_counter.sv
// Window accumulator: counts accepted bits and ones, latches the window
// exponent on the first bit of each window and flags the completing bit.
module sn_window_counter
  import sn_pkg::*;
#(
  parameter int MAX_LOG2_LEN = SN_MAX_LOG2_LEN,
  parameter int CNT_W        = MAX_LOG2_LEN + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_accept,
  input  logic             i_bit,
  input  logic [3:0]       i_win_log2,
  output logic             o_complete,
  output logic [CNT_W-1:0] o_ones_next,
  output logic [3:0]       o_log2,
  output logic             o_busy
);

  localparam logic [3:0] MAX_L = 4'(MAX_LOG2_LEN);
  localparam logic [MAX_LOG2_LEN-1:0] IDX_ALL_ONES = '1;

  logic [MAX_LOG2_LEN-1:0] r_bit_idx;
  logic [CNT_W-1:0]        r_ones;
  logic [3:0]              r_log2;

  logic [3:0]              w_req_log2;
  logic [3:0]              w_log2;
  logic [MAX_LOG2_LEN-1:0] w_last_idx;
  logic                    w_first;

  // On the first bit of a window the live (clamped) request is used so an
  // L=0 window can complete on that same bit; afterwards the latched copy.
  always_comb begin
    w_req_log2  = (i_win_log2 > MAX_L) ? MAX_L : i_win_log2;
    w_first     = (r_bit_idx == '0);
    w_log2      = w_first ? w_req_log2 : r_log2;
    w_last_idx  = IDX_ALL_ONES >> (MAX_L - w_log2);
    o_complete  = i_accept && (r_bit_idx == w_last_idx);
    o_ones_next = r_ones + CNT_W'(i_bit);
    o_log2      = w_log2;
    o_busy      = !w_first;
  end

  // Accumulate accepted bits; wrap to zero on the completing bit so the
  // next accepted bit opens a new window with no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_idx <= '0;
      r_ones    <= '0;
      r_log2    <= '0;
    end else if (i_clear) begin
      r_bit_idx <= '0;
      r_ones    <= '0;
      r_log2    <= '0;
    end else if (i_accept) begin
      if (o_complete) begin
        r_bit_idx <= '0;
        r_ones    <= '0;
      end else begin
        r_bit_idx <= r_bit_idx + 1'b1;
        r_ones    <= o_ones_next;
      end
      if (w_first) begin
        r_log2 <= w_req_log2;
      end
    end
  end

endmodule

// File: rtl/sn_stream_decoder.sv
// Stochastic bitstream to binary converter: run/pause/one-shot control and
// a valid/ready output register around the window counter.
module sn_stream_decoder
  import sn_pkg::*;
#(
  parameter int MAX_LOG2_LEN = SN_MAX_LOG2_LEN,
  parameter int CNT_W        = MAX_LOG2_LEN + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             oneshot,
  input  logic [3:0]       win_log2,
  input  logic             sn_valid,
  input  logic             sn_bit,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count,
  output logic [CNT_W:0]   out_bipolar,
  output logic [3:0]       out_log2,
  output logic             busy,
  output logic             overrun
);

  localparam int BIP_W = CNT_W + 1;

  logic [1:0]       r_state;
  logic             r_valid;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W:0]   r_bipolar;
  logic [3:0]       r_log2;
  logic             r_overrun;

  logic             w_accept;
  logic             w_complete;
  logic [CNT_W-1:0] w_ones_next;
  logic [3:0]       w_log2;
  logic             w_busy;

  assign w_accept = en && sn_valid && (r_state == ST_RUN) && !clear;

  sn_window_counter #(
    .MAX_LOG2_LEN (MAX_LOG2_LEN),
    .CNT_W        (CNT_W)
  ) u_window (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (clear),
    .i_accept    (w_accept),
    .i_bit       (sn_bit),
    .i_win_log2  (win_log2),
    .o_complete  (w_complete),
    .o_ones_next (w_ones_next),
    .o_log2      (w_log2),
    .o_busy      (w_busy)
  );

  // Run control: en pauses without losing the window; a one-shot result
  // parks the decoder in DONE until clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (clear) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (en) r_state <= ST_RUN;
        ST_RUN: begin
          if (!en) begin
            r_state <= ST_IDLE;
          end else if (w_complete && oneshot) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_DONE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output register: a new result always wins over the handshake; losing
  // an unconsumed result sets the sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_count   <= '0;
      r_bipolar <= '0;
      r_log2    <= '0;
      r_overrun <= 1'b0;
    end else if (clear) begin
      r_valid   <= 1'b0;
      r_count   <= '0;
      r_bipolar <= '0;
      r_log2    <= '0;
      r_overrun <= 1'b0;
    end else if (w_complete) begin
      r_valid   <= 1'b1;
      r_count   <= w_ones_next;
      r_bipolar <= BIP_W'(sn_bipolar({{(SN_WIDE_CNT_W-CNT_W){1'b0}}, w_ones_next}, w_log2));
      r_log2    <= w_log2;
      if (r_valid && !out_ready) begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_count   = r_count;
  assign out_bipolar = r_bipolar;
  assign out_log2    = r_log2;
  assign busy        = w_busy;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_sn_stream_decoder.sv
// Directed bench for sn_stream_decoder with hand-computed expected results.
module tb_sn_stream_decoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clear;
  logic       oneshot;
  logic [3:0] win_log2;
  logic       sn_valid;
  logic       sn_bit;
  logic       out_ready;
  logic       out_valid;
  logic [8:0] out_count;
  logic [9:0] out_bipolar;
  logic [3:0] out_log2;
  logic       busy;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  sn_stream_decoder #(.MAX_LOG2_LEN(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .clear       (clear),
    .oneshot     (oneshot),
    .win_log2    (win_log2),
    .sn_valid    (sn_valid),
    .sn_bit      (sn_bit),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_count   (out_count),
    .out_bipolar (out_bipolar),
    .out_log2    (out_log2),
    .busy        (busy),
    .overrun     (overrun)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one stream sample for a single clock.
  task automatic applyStimulus(input logic v, input logic b);
    sn_valid = v;
    sn_bit   = b;
    tick();
    sn_valid = 1'b0;
  endtask

  // Clear everything, then let the FSM step IDLE -> RUN with en high.
  task automatic restart();
    sn_valid = 1'b0;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    tick();
  endtask

  int signedBip;

  always_comb signedBip = int'($signed(out_bipolar));

  initial begin
    logic [7:0] pat;
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; oneshot = 1'b0;
    win_log2 = 4'd3; sn_valid = 1'b0; sn_bit = 1'b0; out_ready = 1'b1;
    #12;
    checkOutput("rst_valid",   int'(out_valid), 0);
    checkOutput("rst_count",   int'(out_count), 0);
    checkOutput("rst_bipolar", signedBip, 0);
    checkOutput("rst_log2",    int'(out_log2), 0);
    checkOutput("rst_busy",    int'(busy), 0);
    checkOutput("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] L=3 continuous");
    en = 1'b1;
    tick();
    pat = 8'b0100_1101;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, pat[i]);
    checkOutput("l3_busy_mid",  int'(busy), 1);
    checkOutput("l3_valid_mid", int'(out_valid), 0);
    applyStimulus(1'b1, pat[7]);
    checkOutput("l3_valid",   int'(out_valid), 1);
    checkOutput("l3_count",   int'(out_count), 4);
    checkOutput("l3_bipolar", signedBip, 0);
    checkOutput("l3_log2",    int'(out_log2), 3);
    checkOutput("l3_busy_end", int'(busy), 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("l3_valid_drop", int'(out_valid), 0);
    checkOutput("l3_next_busy",  int'(busy), 1);

    $display("[TB] L=4 all ones / all zeros");
    win_log2 = 4'd4;
    restart();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("l4_ones_count",   int'(out_count), 16);
    checkOutput("l4_ones_bipolar", signedBip, 16);
    checkOutput("l4_ones_log2",    int'(out_log2), 4);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("l4_zero_valid",   int'(out_valid), 1);
    checkOutput("l4_zero_count",   int'(out_count), 0);
    checkOutput("l4_zero_bipolar", signedBip, -16);
    checkOutput("l4_zero_overrun", int'(overrun), 0);

    $display("[TB] L=2 overrun");
    win_log2  = 4'd2;
    out_ready = 1'b0;
    restart();
    pat = 8'b0001_0111;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, pat[i]);
    checkOutput("l2_first_count",   int'(out_count), 3);
    checkOutput("l2_first_bipolar", signedBip, 2);
    checkOutput("l2_first_overrun", int'(overrun), 0);
    for (int i = 4; i < 8; i++) applyStimulus(1'b1, pat[i]);
    checkOutput("l2_second_count",   int'(out_count), 1);
    checkOutput("l2_second_bipolar", signedBip, -2);
    checkOutput("l2_overrun",        int'(overrun), 1);
    checkOutput("l2_valid_held",     int'(out_valid), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("l2_clr_valid",   int'(out_valid), 0);
    checkOutput("l2_clr_overrun", int'(overrun), 0);
    checkOutput("l2_clr_count",   int'(out_count), 0);

    $display("[TB] L=3 oneshot");
    win_log2  = 4'd3;
    out_ready = 1'b1;
    oneshot   = 1'b1;
    restart();
    pat = 8'b1011_1011;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, pat[i]);
    checkOutput("os_valid",   int'(out_valid), 1);
    checkOutput("os_count",   int'(out_count), 6);
    checkOutput("os_bipolar", signedBip, 4);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("os_done_valid", int'(out_valid), 0);
    checkOutput("os_done_busy",  int'(busy), 0);
    checkOutput("os_done_count", int'(out_count), 6);
    restart();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("os_again_valid",   int'(out_valid), 1);
    checkOutput("os_again_bipolar", signedBip, -8);
    oneshot = 1'b0;

    $display("[TB] pause and mid-window L change");
    restart();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    en       = 1'b0;
    win_log2 = 4'd5;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("pause_busy",  int'(busy), 1);
    checkOutput("pause_valid", int'(out_valid), 0);
    en = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("pause_7_valid", int'(out_valid), 0);
    checkOutput("pause_7_busy",  int'(busy), 1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("pause_valid_end", int'(out_valid), 1);
    checkOutput("pause_count",     int'(out_count), 5);
    checkOutput("pause_bipolar",   signedBip, 2);
    checkOutput("pause_log2",      int'(out_log2), 3);

    $display("[TB] clamp and async reset");
    win_log2  = 4'd15;
    out_ready = 1'b0;
    restart();
    for (int i = 0; i < 256; i++) applyStimulus(1'b1, (i % 4) == 0);
    checkOutput("big_valid",   int'(out_valid), 1);
    checkOutput("big_count",   int'(out_count), 64);
    checkOutput("big_bipolar", signedBip, -128);
    checkOutput("big_log2",    int'(out_log2), 8);
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("big_mid_busy",    int'(busy), 1);
    checkOutput("big_mid_valid",   int'(out_valid), 1);
    checkOutput("big_mid_overrun", int'(overrun), 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", int'(out_valid), 0);
    checkOutput("arst_busy",  int'(busy), 0);
    checkOutput("arst_count", int'(out_count), 0);
    checkOutput("arst_log2",  int'(out_log2), 0);
    #10;
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
